// File: rtl/qspi_seq_pkg.sv
// Shared encodings for the flash operation sequencer: FSM states, command
// phases, command-engine select values and completion status codes.
package qspi_seq_pkg;

  // Top-level sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StGap,
    StDone
  } seq_state_e;

  // Which engine command the sequencer is currently working on.
  typedef enum logic [1:0] {
    PhWren,
    PhMain,
    PhPoll
  } seq_phase_e;

  // Command-select values steering the upstream opcode/length mux.
  localparam logic [1:0] CE_SEL_MAIN = 2'd0;
  localparam logic [1:0] CE_SEL_WREN = 2'd1;
  localparam logic [1:0] CE_SEL_RDSR = 2'd2;

  // Completion status codes.
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_ABORT   = 2'd2;
  localparam logic [1:0] ST_FAIL    = 2'd3;

  // Operation kinds; any other value behaves as a single command.
  localparam logic [1:0] KIND_SINGLE = 2'd0;
  localparam logic [1:0] KIND_WRITE  = 2'd1;
  localparam logic [1:0] KIND_POLL   = 2'd2;

  // Map a phase onto the engine command select.
  function automatic logic [1:0] phase_to_sel(input seq_phase_e ph);
    logic [1:0] sel;
    sel = CE_SEL_MAIN;
    if (ph == PhWren) begin
      sel = CE_SEL_WREN;
    end else if (ph == PhPoll) begin
      sel = CE_SEL_RDSR;
    end
    return sel;
  endfunction

endpackage

// File: rtl/seq_gap_timer.sv
// Loadable down-counter with a zero flag. Spaces out successive status polls.
module seq_gap_timer #(
  parameter int unsigned Width = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [Width-1:0] r_cnt;

  // Load takes priority; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - Width'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/flash_op_seq.sv
// Multi-step flash operation sequencer. Runs WREN, the main command and
// repeated RDSR polls as separate command-engine commands from one start,
// finishing on WIP clear, flash fail, poll timeout or abort.
module flash_op_seq
  import qspi_seq_pkg::*;
#(
  parameter int unsigned POLL_GAP  = 64,
  parameter int unsigned TIMEOUT_W = 24,
  parameter int unsigned WIP_BIT   = 0,
  parameter int unsigned FAIL_BIT  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_start_i,
  input  logic [1:0]           op_kind_i,
  input  logic                 op_use_dma_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 abort_i,
  output logic                 op_busy_o,
  output logic                 op_done_o,
  output logic [1:0]           op_status_o,
  output logic [TIMEOUT_W-1:0] poll_cnt_o,
  output logic                 ce_trigger_o,
  output logic                 ce_dma_en_o,
  output logic [1:0]           ce_sel_o,
  input  logic                 ce_busy_i,
  input  logic                 ce_cmd_done_i,
  input  logic [7:0]           sr_data_i
);

  // Gap counter must hold POLL_GAP-1.
  localparam int unsigned GapW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  seq_state_e           r_state;
  seq_phase_e           r_phase;
  logic                 r_kind_write;
  logic                 r_use_dma;
  logic [TIMEOUT_W-1:0] r_timeout;
  logic [TIMEOUT_W-1:0] r_poll_cnt;
  logic                 r_abort;
  logic                 r_busy;
  logic                 r_done;
  logic [1:0]           r_status;
  logic                 r_trigger;
  logic                 r_dma_en;
  logic [1:0]           r_sel;

  logic                 w_abort;
  logic [TIMEOUT_W-1:0] w_poll_cnt_inc;
  logic                 w_timeout_hit;
  logic                 w_sr_fail;
  logic                 w_sr_wip;
  logic                 w_gap_load;
  logic                 w_gap_dec;
  logic                 w_gap_zero;
  logic                 w_unused_sr;

  // Abort input counts in the same cycle it arrives, not only once latched.
  assign w_abort = r_abort | abort_i;

  // Saturating poll count and timeout test on the post-increment value.
  assign w_poll_cnt_inc = (&r_poll_cnt) ? r_poll_cnt : r_poll_cnt + TIMEOUT_W'(1);
  assign w_timeout_hit  = (r_timeout != '0) && (w_poll_cnt_inc == r_timeout);

  assign w_sr_fail   = sr_data_i[FAIL_BIT];
  assign w_sr_wip    = sr_data_i[WIP_BIT];
  assign w_unused_sr = ^sr_data_i;

  // Reload on every poll completion; only matters when the next state is GAP.
  assign w_gap_load = (r_state == StWait) && ce_cmd_done_i && (r_phase == PhPoll);
  assign w_gap_dec  = (r_state == StGap);

  seq_gap_timer #(
    .Width (GapW)
  ) u_gap_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_gap_load),
    .i_load_val (GapW'(POLL_GAP - 1)),
    .i_dec      (w_gap_dec),
    .o_zero     (w_gap_zero)
  );

  // Sequencer FSM with registered engine and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_phase      <= PhWren;
      r_kind_write <= 1'b0;
      r_use_dma    <= 1'b0;
      r_timeout    <= '0;
      r_poll_cnt   <= '0;
      r_abort      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_status     <= ST_OK;
      r_trigger    <= 1'b0;
      r_dma_en     <= 1'b0;
      r_sel        <= CE_SEL_MAIN;
    end else begin
      r_trigger <= 1'b0;
      r_done    <= 1'b0;
      if ((r_state != StIdle) && abort_i) begin
        r_abort <= 1'b1;
      end

      unique case (r_state)
        StIdle: begin
          if (op_start_i) begin
            r_kind_write <= (op_kind_i == KIND_WRITE);
            r_use_dma    <= op_use_dma_i;
            r_timeout    <= timeout_i;
            r_poll_cnt   <= '0;
            r_abort      <= 1'b0;
            r_status     <= ST_OK;
            r_busy       <= 1'b1;
            r_state      <= StIssue;
            if (op_kind_i == KIND_WRITE) begin
              r_phase <= PhWren;
            end else if (op_kind_i == KIND_POLL) begin
              r_phase <= PhPoll;
            end else begin
              r_phase <= PhMain;
            end
          end
        end

        StIssue: begin
          if (w_abort) begin
            r_status <= ST_ABORT;
            r_done   <= 1'b1;
            r_state  <= StDone;
          end else if (!ce_busy_i) begin
            r_trigger <= 1'b1;
            r_sel     <= phase_to_sel(r_phase);
            r_dma_en  <= (r_phase == PhMain) && r_use_dma;
            r_state   <= StWait;
          end
        end

        StWait: begin
          if (ce_cmd_done_i) begin
            if (r_phase == PhPoll) begin
              r_poll_cnt <= w_poll_cnt_inc;
            end
            if (w_abort) begin
              // Abort overrides whatever the completing command decided.
              r_status <= ST_ABORT;
              r_done   <= 1'b1;
              r_state  <= StDone;
            end else if (r_phase == PhWren) begin
              r_phase <= PhMain;
              r_state <= StIssue;
            end else if (r_phase == PhMain) begin
              if (r_kind_write) begin
                r_phase <= PhPoll;
                r_state <= StIssue;
              end else begin
                r_status <= ST_OK;
                r_done   <= 1'b1;
                r_state  <= StDone;
              end
            end else if (w_sr_fail) begin
              r_status <= ST_FAIL;
              r_done   <= 1'b1;
              r_state  <= StDone;
            end else if (!w_sr_wip) begin
              r_status <= ST_OK;
              r_done   <= 1'b1;
              r_state  <= StDone;
            end else if (w_timeout_hit) begin
              r_status <= ST_TIMEOUT;
              r_done   <= 1'b1;
              r_state  <= StDone;
            end else begin
              r_state <= StGap;
            end
          end
        end

        StGap: begin
          if (w_abort) begin
            r_status <= ST_ABORT;
            r_done   <= 1'b1;
            r_state  <= StDone;
          end else if (w_gap_zero) begin
            r_state <= StIssue;
          end
        end

        StDone: begin
          r_busy   <= 1'b0;
          r_sel    <= CE_SEL_MAIN;
          r_dma_en <= 1'b0;
          r_state  <= StIdle;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign op_busy_o    = r_busy;
  assign op_done_o    = r_done;
  assign op_status_o  = r_status;
  assign poll_cnt_o   = r_poll_cnt;
  assign ce_trigger_o = r_trigger;
  assign ce_dma_en_o  = r_dma_en;
  assign ce_sel_o     = r_sel;

endmodule
